dma_streamer: RTL and testbench
===============================

Name: dma_streamer

Overview:
- Converts one DMA descriptor (base address, byte count, mode) into a sequence of AXI burst requests on the s_dma_axi_req_t / s_dma_axi_resp_t streamer interface of the AXI master interface block.
- One instance sits upstream of the read request port and one upstream of the write request port.
- Splits the transfer so that no burst exceeds the maximum length or crosses a 4 KB boundary.
- Issues an unaligned byte tail as a separate single-beat burst with a trimmed strobe.

Parameters:
- ADDR_WIDTH, 32, address width (matches `DMA_ADDR_WIDTH).
- DATA_WIDTH, 32, AXI data width in bits. BYTES = DATA_WIDTH/8.
- MAX_BURST, 256, maximum beats per INCR burst (1..256). FIXED bursts are additionally capped at 16.
- BYTES_WIDTH, 32, width of the descriptor byte count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- desc_valid_i  in  1  descriptor valid.
- desc_ready_o  out  1  high only in IDLE.
- desc_addr_i  in  ADDR_WIDTH  start address; must be BYTES-aligned.
- desc_bytes_i  in  BYTES_WIDTH  transfer length in bytes.
- desc_mode_i  in  1  DMA_MODE_INCR or DMA_MODE_FIXED.
- abort_i  in  1  stop issuing requests.
- dma_axi_req_o  out  $bits(s_dma_axi_req_t)  fields valid, addr, alen, size, strb, mode.
- dma_axi_resp_i  in  $bits(s_dma_axi_resp_t)  field ready; a handshake is valid && ready.
- busy_o  out  1  FSM not IDLE.
- done_o  out  1  one-cycle pulse at the end of a descriptor.
- err_o  out  1  one-cycle pulse when the start address is misaligned.

Behaviour:
- Reset values: all req_o fields 0, busy_o 0, done_o 0, err_o 0, desc_ready_o 1, FSM in IDLE.
- FSM states: IDLE, CALC, REQ, DONE.
- IDLE:
  - On desc_valid_i: latch addr, bytes and mode.
  - If addr[log2(BYTES)-1:0] != 0, pulse err_o and stay in IDLE.
  - Else if bytes == 0, go to DONE.
  - Else go to CALC.
- CALC (registered, 1 cycle): compute the next burst.
  - full_beats = bytes_left >> log2(BYTES); tail = bytes_left % BYTES.
  - If full_beats == 0: beats = 1, strb = (1 << tail) - 1.
  - Else: beats = min(full_beats, cap, to4k); strb = all ones.
  - cap = MAX_BURST for INCR, min(16, MAX_BURST) for FIXED.
  - to4k = (4096 - addr[11:0]) >> log2(BYTES) for INCR; unlimited for FIXED.
  - alen = beats - 1; size = log2(BYTES).
  - Go to REQ.
- REQ:
  - valid = 1. All fields are held stable until handshake; valid never drops before ready.
  - On handshake: bytes_left -= (tail burst ? tail : beats*BYTES).
  - On handshake in INCR mode: addr += beats*BYTES. In FIXED mode addr is unchanged.
  - Then: if bytes_left == 0 or abort is latched, go to DONE; else go to CALC.
  - Request latency: first valid appears 2 cycles after descriptor acceptance; 1 idle cycle between consecutive requests.
- DONE: pulse done_o for 1 cycle, go to IDLE.
- Abort:
  - abort_i is sticky (latched) while busy_o is high.
  - In CALC: go straight to DONE.
  - In REQ: complete the pending handshake, then go to DONE.
  - Cleared on entry to IDLE.
  - Bytes not yet requested are dropped.
- Arithmetic: the address wraps modulo 2^ADDR_WIDTH with no error. bytes_left never underflows because the tail burst consumes exactly tail bytes.
- desc_valid_i while busy is ignored.
- Async reset mid-burst returns to the reset state immediately; valid drops. Recovery is the system's job.

Decomposition:
- Add to dma_utils_pkg:
  - streamer FSM enum (ST_IDLE, ST_CALC, ST_REQ, ST_DONE);
  - localparam AXI_4K = 4096;
  - a helper function to compute beats.
- Reuse the existing s_dma_axi_req_t, s_dma_axi_resp_t and DMA mode enum.
- One optional sub-module, dma_burst_calc: the combinational computation of beats, strb and alen, so that it can be unit-tested alone.

Test Plan (DATA_WIDTH=32, MAX_BURST=256):
- INCR, addr 0x1000, 64 B, ready=1 -> one req: addr 0x1000, alen 15, size 2, strb 0xF; done_o 1 cycle after the handshake.
- INCR, addr 0x0FF0, 64 B -> req1 addr 0x0FF0 alen 3; req2 addr 0x1000 alen 11; no 4 KB crossing.
- INCR, addr 0x0, 2048 B -> req1 addr 0x0 alen 255; req2 addr 0x400 alen 255; then done.
- INCR, addr 0x2000, 10 B -> req1 addr 0x2000 alen 1 strb 0xF; req2 addr 0x2008 alen 0 strb 0x3.
- FIXED, addr 0x3000, 96 B -> req1 addr 0x3000 alen 15; req2 addr 0x3000 alen 7; mode FIXED on both.
- Error, abort and reset cases:
  - addr 0x1002 -> err_o pulse, no valid.
  - 0 B -> done_o, no valid.
  - 2048 B with ready held low 5 cycles -> fields stable; abort asserted during the wait -> that request completes, then done_o and no further req.
  - Reset asserted mid-REQ -> valid=0 immediately.

Source files
------------

// File: rtl/dma_streamer_pkg.sv
// Shared types for the DMA burst streamer: AXI streamer request/response
// structs, DMA mode, FSM states and the burst-length helper.
package dma_streamer_pkg;

  localparam int DMA_ADDR_WIDTH  = 32;
  localparam int DMA_DATA_WIDTH  = 32;
  localparam int DMA_STRB_WIDTH  = DMA_DATA_WIDTH / 8;
  localparam int AXI_4K          = 4096;
  localparam int FIXED_MAX_BEATS = 16;

  typedef enum logic {
    DMA_MODE_INCR  = 1'b0,
    DMA_MODE_FIXED = 1'b1
  } dma_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_DONE
  } streamer_state_e;

  typedef struct packed {
    logic                      valid;
    logic [DMA_ADDR_WIDTH-1:0] addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [DMA_STRB_WIDTH-1:0] strb;
    dma_mode_e                 mode;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

  // Smallest of the remaining full beats, the mode cap and the 4 KB headroom.
  function automatic logic [8:0] f_burst_beats(input logic [31:0] full_beats,
                                               input logic [31:0] cap,
                                               input logic [31:0] to4k);
    logic [31:0] m;
    m = (full_beats < cap) ? full_beats : cap;
    m = (to4k < m) ? to4k : m;
    return 9'(m);
  endfunction

endpackage

// File: rtl/dma_streamer_if.sv
// Request/response bundle between a DMA streamer and the AXI master block.
interface dma_streamer_if;
  dma_streamer_pkg::s_dma_axi_req_t  req;
  dma_streamer_pkg::s_dma_axi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/dma_streamer_burst_calc.sv
// Combinational sizing of the next burst: beat count, AXI length and strobe,
// honouring the burst cap and the 4 KB boundary.
module dma_streamer_burst_calc
  import dma_streamer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 256,
  parameter int BYTES_WIDTH = 32
) (
  input  logic [11:0]              i_addr_lo,
  input  logic [BYTES_WIDTH-1:0]   i_bytes_left,
  input  dma_mode_e                i_mode,
  output logic [8:0]               o_beats,
  output logic [7:0]               o_alen,
  output logic [DATA_WIDTH/8-1:0]  o_strb,
  output logic                     o_tail
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LOG2B     = $clog2(BYTES);
  localparam int FIXED_CAP = (MAX_BURST < FIXED_MAX_BEATS) ? MAX_BURST : FIXED_MAX_BEATS;

  logic [BYTES_WIDTH-1:0] w_full_beats;
  logic [LOG2B-1:0]       w_tail_bytes;
  logic [12:0]            w_to4k_bytes;
  logic [31:0]            w_cap;
  logic [31:0]            w_to4k;
  logic [BYTES-1:0]       w_strb_tail;

  assign w_full_beats = i_bytes_left >> LOG2B;
  assign w_tail_bytes = i_bytes_left[LOG2B-1:0];
  assign w_to4k_bytes = 13'(AXI_4K) - {1'b0, i_addr_lo};
  assign w_cap        = (i_mode == DMA_MODE_FIXED) ? 32'(FIXED_CAP) : 32'(MAX_BURST);
  // FIXED bursts never advance the address, so the 4 KB limit does not apply.
  assign w_to4k       = (i_mode == DMA_MODE_FIXED) ? w_cap : 32'(w_to4k_bytes >> LOG2B);

  always_comb begin
    w_strb_tail = '0;
    for (int i = 0; i < BYTES; i++) w_strb_tail[i] = (i < int'(w_tail_bytes));
  end

  assign o_tail  = (w_full_beats == '0);
  assign o_beats = o_tail ? 9'd1 : f_burst_beats(32'(w_full_beats), w_cap, w_to4k);
  assign o_alen  = 8'(o_beats - 9'd1);
  assign o_strb  = o_tail ? w_strb_tail : '1;

endmodule

// File: rtl/dma_streamer.sv
// Turns one DMA descriptor into a sequence of AXI burst requests, split on
// burst cap and 4 KB boundaries, with a trimmed single-beat tail burst.
module dma_streamer
  import dma_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMA_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DMA_DATA_WIDTH,
  parameter int MAX_BURST   = 256,
  parameter int BYTES_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  input  logic [ADDR_WIDTH-1:0]  desc_addr_i,
  input  logic [BYTES_WIDTH-1:0] desc_bytes_i,
  input  dma_mode_e              desc_mode_i,
  input  logic                   abort_i,
  dma_streamer_if.master         dma_axi,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  streamer_state_e        r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BYTES_WIDTH-1:0] r_bytes_left;
  dma_mode_e              r_mode;
  logic                   r_abort;
  logic                   r_tail;
  logic [8:0]             r_beats;
  s_dma_axi_req_t         r_req;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_desc_ready;

  logic [8:0]             w_beats;
  logic [7:0]             w_alen;
  logic [BYTES-1:0]       w_strb;
  logic                   w_tail;
  logic                   w_abort;
  logic                   w_hs;
  logic [BYTES_WIDTH-1:0] w_consumed;
  logic [ADDR_WIDTH-1:0]  w_step;

  dma_streamer_burst_calc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MAX_BURST   (MAX_BURST),
    .BYTES_WIDTH (BYTES_WIDTH)
  ) u_calc (
    .i_addr_lo    (r_addr[11:0]),
    .i_bytes_left (r_bytes_left),
    .i_mode       (r_mode),
    .o_beats      (w_beats),
    .o_alen       (w_alen),
    .o_strb       (w_strb),
    .o_tail       (w_tail)
  );

  assign w_abort    = r_abort | abort_i;
  assign w_hs       = r_req.valid & dma_axi.resp.ready;
  // A tail burst carries only the leftover bytes, so bytes_left lands on zero.
  assign w_consumed = r_tail ? BYTES_WIDTH'(r_bytes_left[LOG2B-1:0])
                             : (BYTES_WIDTH'(r_beats) << LOG2B);
  assign w_step     = ADDR_WIDTH'(r_beats) << LOG2B;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_bytes_left <= '0;
      r_mode       <= DMA_MODE_INCR;
      r_abort      <= 1'b0;
      r_tail       <= 1'b0;
      r_beats      <= '0;
      r_req        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_desc_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_busy && abort_i) r_abort <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (desc_valid_i) begin
            r_addr       <= desc_addr_i;
            r_bytes_left <= desc_bytes_i;
            r_mode       <= desc_mode_i;
            if (desc_addr_i[LOG2B-1:0] != '0) begin
              r_err <= 1'b1;
            end else begin
              r_busy       <= 1'b1;
              r_desc_ready <= 1'b0;
              if (desc_bytes_i == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_CALC;
              end
            end
          end
        end
        ST_CALC: begin
          if (w_abort) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= ST_REQ;
            r_tail       <= w_tail;
            r_beats      <= w_beats;
            r_req.valid  <= 1'b1;
            r_req.addr   <= r_addr;
            r_req.alen   <= w_alen;
            r_req.size   <= 3'(LOG2B);
            r_req.strb   <= w_strb;
            r_req.mode   <= r_mode;
          end
        end
        ST_REQ: begin
          if (w_hs) begin
            r_req.valid  <= 1'b0;
            r_bytes_left <= r_bytes_left - w_consumed;
            if (r_mode == DMA_MODE_INCR) r_addr <= r_addr + w_step;
            if ((r_bytes_left == w_consumed) || w_abort) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_desc_ready <= 1'b1;
          r_abort      <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_axi.req  = r_req;
  assign desc_ready_o = r_desc_ready;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_dma_streamer.sv
// Directed bench for dma_streamer with 32-bit data and 256-beat bursts.
module tb_dma_streamer;
  import dma_streamer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_addr = '0;
  logic [31:0] desc_bytes = '0;
  dma_mode_e   desc_mode = DMA_MODE_INCR;
  logic        abort = 1'b0;
  logic        busy, done, err;
  int          checks = 0;
  int          errors = 0;

  dma_streamer_if axi();

  dma_streamer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_BURST  (256),
    .BYTES_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .desc_valid_i (desc_valid),
    .desc_ready_o (desc_ready),
    .desc_addr_i  (desc_addr),
    .desc_bytes_i (desc_bytes),
    .desc_mode_i  (desc_mode),
    .abort_i      (abort),
    .dma_axi      (axi),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_desc(input logic [31:0] a, input logic [31:0] b, input dma_mode_e m);
    desc_addr  = a;
    desc_bytes = b;
    desc_mode  = m;
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, records it and steps past the handshake edge.
  task automatic capture_req(output bit ok, output s_dma_axi_req_t r, output int waited);
    ok = 1'b0;
    r = '0;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      if (axi.req.valid === 1'b1) begin
        ok = 1'b1;
        r = axi.req;
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (axi.req !== '0) begin
      errors++; $display("FAIL reset_req: got %h expected 0", axi.req);
    end
    checks++;
    if ({busy, done, err, desc_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_flags: got %b expected 0001", {busy, done, err, desc_ready});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    s_dma_axi_req_t r, e;
    bit ok;
    int w;
    send_desc(32'h1000, 32'd64, DMA_MODE_INCR);
    capture_req(ok, r, w);
    checks++;
    if (!ok || w != 1) begin
      errors++; $display("FAIL single_latency: got ok=%0d wait=%0d expected ok=1 wait=1", ok, w);
    end
    e = '{valid: 1'b1, addr: 32'h1000, alen: 8'd15, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR};
    checks++;
    if (r !== e) begin
      errors++; $display("FAIL single_req: got %h expected %h", r, e);
    end
    checks++;
    if (done !== 1'b1 || axi.req.valid !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b valid=%b expected 1 0", done, axi.req.valid);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, desc_ready} !== 3'b001) begin
      errors++; $display("FAIL single_idle: got %b expected 001", {done, busy, desc_ready});
    end
  endtask

  task automatic test_split(input string name, input logic [31:0] a, input logic [31:0] b,
                            input dma_mode_e m, input s_dma_axi_req_t e0, input s_dma_axi_req_t e1);
    s_dma_axi_req_t r;
    bit ok;
    int w;
    send_desc(a, b, m);
    capture_req(ok, r, w);
    checks++;
    if (r !== e0) begin
      errors++; $display("FAIL %s_req1: got %h expected %h", name, r, e0);
    end
    capture_req(ok, r, w);
    checks++;
    if (r !== e1 || w != 1) begin
      errors++; $display("FAIL %s_req2: got %h gap=%0d expected %h gap=1", name, r, w, e1);
    end
    checks++;
    if (done !== 1'b1 || axi.req.valid !== 1'b0) begin
      errors++; $display("FAIL %s_done: got done=%b valid=%b expected 1 0", name, done, axi.req.valid);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    int seen = 0;
    send_desc(32'h1002, 32'd64, DMA_MODE_INCR);
    checks++;
    if ({err, busy, desc_ready} !== 3'b101) begin
      errors++; $display("FAIL misaligned_err: got %b expected 101", {err, busy, desc_ready});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (axi.req.valid !== 1'b0 || err !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL misaligned_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_zero_bytes;
    int seen = 0;
    send_desc(32'h0100, 32'd0, DMA_MODE_INCR);
    checks++;
    if ({done, busy, axi.req.valid} !== 3'b110) begin
      errors++; $display("FAIL zero_done: got %b expected 110", {done, busy, axi.req.valid});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (axi.req.valid !== 1'b0 || done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_quiet: got %0d active busy=%b expected 0 0", seen, busy);
    end
  endtask

  task automatic test_abort;
    s_dma_axi_req_t r0, e;
    int stable = 0;
    int seen = 0;
    axi.resp.ready = 1'b0;
    send_desc(32'h0, 32'd2048, DMA_MODE_INCR);
    for (int i = 0; i < 10 && axi.req.valid !== 1'b1; i++) @(negedge clk);
    r0 = axi.req;
    e = '{valid: 1'b1, addr: 32'h0, alen: 8'd255, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR};
    checks++;
    if (r0 !== e) begin
      errors++; $display("FAIL abort_req: got %h expected %h", r0, e);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) abort = 1'b1;
      if (i == 3) abort = 1'b0;
      @(negedge clk);
      if (axi.req === r0) stable++;
    end
    checks++;
    if (stable != 5) begin
      errors++; $display("FAIL abort_stable: got %0d stable cycles expected 5", stable);
    end
    axi.resp.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || axi.req.valid !== 1'b0) begin
      errors++; $display("FAIL abort_done: got done=%b valid=%b expected 1 0", done, axi.req.valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi.req.valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_more: got %0d valid cycles busy=%b expected 0 0", seen, busy);
    end
  endtask

  task automatic test_reset_mid_req;
    bit ok = 1'b0;
    axi.resp.ready = 1'b0;
    send_desc(32'h5000, 32'd256, DMA_MODE_INCR);
    for (int i = 0; i < 10; i++) begin
      if (axi.req.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (!ok || {axi.req.valid, busy, desc_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_mid_req: got seen=%0d %b expected seen=1 001", ok, {axi.req.valid, busy, desc_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    axi.resp.ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    axi.resp.ready = 1'b1;
    test_reset();
    test_single();
    test_split("cross4k", 32'h0FF0, 32'd64, DMA_MODE_INCR,
      '{valid: 1'b1, addr: 32'h0FF0, alen: 8'd3,  size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR},
      '{valid: 1'b1, addr: 32'h1000, alen: 8'd11, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR});
    test_split("maxburst", 32'h0, 32'd2048, DMA_MODE_INCR,
      '{valid: 1'b1, addr: 32'h0000, alen: 8'd255, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR},
      '{valid: 1'b1, addr: 32'h0400, alen: 8'd255, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR});
    test_split("tail", 32'h2000, 32'd10, DMA_MODE_INCR,
      '{valid: 1'b1, addr: 32'h2000, alen: 8'd1, size: 3'd2, strb: 4'hF, mode: DMA_MODE_INCR},
      '{valid: 1'b1, addr: 32'h2008, alen: 8'd0, size: 3'd2, strb: 4'h3, mode: DMA_MODE_INCR});
    test_split("fixed", 32'h3000, 32'd96, DMA_MODE_FIXED,
      '{valid: 1'b1, addr: 32'h3000, alen: 8'd15, size: 3'd2, strb: 4'hF, mode: DMA_MODE_FIXED},
      '{valid: 1'b1, addr: 32'h3000, alen: 8'd7,  size: 3'd2, strb: 4'hF, mode: DMA_MODE_FIXED});
    test_misaligned();
    test_zero_bytes();
    test_abort();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
